// File: rtl/trigger_scheduler_pkg.sv
// Shared definitions for the trigger scheduler: FSM states, source bit positions, default widths.
package trigger_scheduler_pkg;

    // Scheduler states (2-bit encoding)
    typedef enum logic [1:0] {
        TsIdle = 2'd0,
        TsPost = 2'd1,
        TsReq  = 2'd2,
        TsDead = 2'd3
    } ts_state_e;

    // Trigger source bit positions within TRIG_IN / TRIG_MASK / TRIG_ID
    localparam int unsigned SrcSb40  = 0;
    localparam int unsigned SrcSb120 = 1;
    localparam int unsigned SrcTot   = 2;
    localparam int unsigned SrcTotd  = 3;
    localparam int unsigned SrcMops  = 4;
    localparam int unsigned SrcExt   = 5;
    localparam int unsigned SrcSoft  = 6;
    localparam int unsigned SrcRand  = 7;

    // Default sizes
    localparam int unsigned DefNsrc      = 8;
    localparam int unsigned DefPostWidth = 12;
    localparam int unsigned DefDeadWidth = 16;
    localparam int unsigned DefCntWidth  = 16;

endpackage

// File: rtl/trig_event_counter.sv
// Event counter with synchronous clear; wraps or saturates at all-ones depending on SATURATE.
module trig_event_counter #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over increment; saturating variant holds at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            if (SATURATE && (&count_q)) begin
                count_d = count_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/trigger_scheduler.sv
// Merges masked trigger-source pulses into one event trigger: post-trigger delay, buffer
// handshake, dead time, with source recording and accepted/missed counting.
module trigger_scheduler
    import trigger_scheduler_pkg::*;
#(
    parameter int unsigned NSRC       = DefNsrc,
    parameter int unsigned POST_WIDTH = DefPostWidth,
    parameter int unsigned DEAD_WIDTH = DefDeadWidth,
    parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
    input  logic                  CLK120,
    input  logic                  RESETN,
    input  logic [NSRC-1:0]       TRIG_IN,
    input  logic [NSRC-1:0]       TRIG_MASK,
    input  logic [POST_WIDTH-1:0] POST_TRIG_DELAY,
    input  logic [DEAD_WIDTH-1:0] DEAD_TIME,
    input  logic                  BUF_FULL,
    input  logic                  BUF_ACK,
    input  logic                  CNT_CLR,
    output logic                  TRIG_OUT,
    output logic [NSRC-1:0]       TRIG_ID,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  TRIG_CNT,
    output logic [CNT_WIDTH-1:0]  MISSED_CNT
);

    ts_state_e             state_q;
    logic                  trig_out_q;
    logic                  busy_q;
    logic [NSRC-1:0]       trig_id_q;
    logic [POST_WIDTH-1:0] post_cnt_q;
    logic [DEAD_WIDTH-1:0] dead_cnt_q;

    logic [NSRC-1:0] masked;
    logic            hit;
    logic            acc_inc;
    logic            miss_inc;

    // Masked sources and event strobes for the counters
    always_comb begin
        masked   = TRIG_IN & TRIG_MASK;
        hit      = |masked;
        acc_inc  = (state_q == TsReq) && BUF_ACK;
        // One miss per cycle regardless of how many sources fire; POST merges instead
        miss_inc = hit && (((state_q == TsIdle) && BUF_FULL) ||
                           (state_q == TsReq) || (state_q == TsDead));
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge CLK120 or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= TsIdle;
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
            trig_id_q  <= '0;
            post_cnt_q <= '0;
            dead_cnt_q <= '0;
        end else begin
            unique case (state_q)
                TsIdle: begin
                    if (hit && !BUF_FULL) begin
                        state_q    <= TsPost;
                        busy_q     <= 1'b1;
                        trig_id_q  <= masked;
                        post_cnt_q <= POST_TRIG_DELAY;
                    end
                end
                TsPost: begin
                    trig_id_q <= trig_id_q | masked;
                    if (post_cnt_q == '0) begin
                        state_q    <= TsReq;
                        trig_out_q <= 1'b1;
                    end else begin
                        post_cnt_q <= post_cnt_q - 1'b1;
                    end
                end
                TsReq: begin
                    // Held indefinitely until the buffer controller acknowledges
                    if (BUF_ACK) begin
                        state_q    <= TsDead;
                        trig_out_q <= 1'b0;
                        dead_cnt_q <= DEAD_TIME;
                    end
                end
                TsDead: begin
                    if (dead_cnt_q == '0) begin
                        state_q <= TsIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= TsIdle;
                    trig_out_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    trig_event_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_trig_cnt (
        .clk_i   (CLK120),
        .rst_ni  (RESETN),
        .clr_i   (CNT_CLR),
        .inc_i   (acc_inc),
        .count_o (TRIG_CNT)
    );

    trig_event_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b1)
    ) u_missed_cnt (
        .clk_i   (CLK120),
        .rst_ni  (RESETN),
        .clr_i   (CNT_CLR),
        .inc_i   (miss_inc),
        .count_o (MISSED_CNT)
    );

    assign TRIG_OUT = trig_out_q;
    assign BUSY     = busy_q;
    assign TRIG_ID  = trig_id_q;

endmodule
